vga_timing_gen: RTL and testbench

Sync-and-scan generator that drives the VGA pins and supplies the scan coordinates consumed by the pixel renderer. It divides the system clock into a pixel tick and runs horizontal and vertical counters with phase state machines. It decodes sync and active-video, then registers the renderer's combinational colour together with sync into the pin stage, so colour and sync leave the block aligned. It sits between the system clock/reset and the VGA connector, upstream of the renderer in the coordinate path and downstream of it in the colour path.

---
 rtl/vga_timing_gen.sv | 150 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA sync-and-scan generator: pixel-tick divider, h/v scan counters with phase FSMs,
// and a registered pin stage that keeps colour and sync aligned one pixel behind the coordinates.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rgb_in_r,
  input  logic [3:0]  rgb_in_g,
  input  logic [3:0]  rgb_in_b,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        pix_tick,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} phase_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [11:0] H_A_END  = 12'(H_ACTIVE - 1);
  localparam logic [11:0] H_FP_END = 12'(H_ACTIVE + H_FP - 1);
  localparam logic [11:0] H_S_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [11:0] H_LAST   = H_TOTAL - 12'd1;

  localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [11:0] V_A_END  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] V_FP_END = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] V_S_END  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [11:0] V_LAST   = V_TOTAL - 12'd1;

  logic [DIV_W-1:0] div_cnt;
  logic [11:0]      h_ext;
  logic [11:0]      v_ext;
  logic             h_end;
  logic             v_end;
  logic             line_end;
  logic             hsync_int;
  logic             vsync_int;
  phase_t           h_state, h_next;
  phase_t           v_state, v_next;

  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_ext    = {1'b0, h_cnt};
  assign v_ext    = {2'b00, v_cnt};
  assign h_end    = (h_ext == H_LAST);
  assign v_end    = (v_ext == V_LAST);
  assign line_end = pix_tick && h_end;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Wrap is an explicit compare against TOTAL-1, so non-power-of-two totals never overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (pix_tick) begin
        h_cnt <= h_end ? 11'd0 : h_cnt + 11'd1;
      end
      if (line_end) begin
        v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_state <= ACTIVE;
      v_state <= ACTIVE;
    end else begin
      h_state <= h_next;
      v_state <= v_next;
    end
  end

  // Each phase advances on the last count of the phase, so the state tracks the counter decode.
  always_comb begin
    h_next = h_state;
    v_next = v_state;
    if (pix_tick) begin
      unique case (h_state)
        ACTIVE:  if (h_ext == H_A_END)  h_next = FP;
        FP:      if (h_ext == H_FP_END) h_next = SYNC;
        SYNC:    if (h_ext == H_S_END)  h_next = BP;
        BP:      if (h_ext == H_LAST)   h_next = ACTIVE;
        default: h_next = ACTIVE;
      endcase
    end
    if (line_end) begin
      unique case (v_state)
        ACTIVE:  if (v_ext == V_A_END)  v_next = FP;
        FP:      if (v_ext == V_FP_END) v_next = SYNC;
        SYNC:    if (v_ext == V_S_END)  v_next = BP;
        BP:      if (v_ext == V_LAST)   v_next = ACTIVE;
        default: v_next = ACTIVE;
      endcase
    end
  end

  assign hsync_int   = (h_state == SYNC);
  assign vsync_int   = (v_state == SYNC);
  assign video_on    = (h_state == ACTIVE) && (v_state == ACTIVE);
  assign line_start  = pix_tick && (h_cnt == 11'd0);
  assign frame_start = line_start && (v_cnt == 10'd0);

  // Colour for the current coordinate is captured together with its sync, one pixel behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hs <= ~SYNC_POL;
      vga_vs <= ~SYNC_POL;
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
    end else if (pix_tick) begin
      vga_hs <= ~(hsync_int ^ SYNC_POL);
      vga_vs <= ~(vsync_int ^ SYNC_POL);
      vga_r  <= video_on ? rgb_in_r : 4'h0;
      vga_g  <= video_on ? rgb_in_g : 4'h0;
      vga_b  <= video_on ? rgb_in_b : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default build (line timing), a shrunken build (whole frames,
// mid-frame reset) and a CLK_DIV=1 build.
module tb_vga_timing_gen;

  typedef struct {
    int         cyc;
    logic [3:0] rgb;
    int         h;
    int         v;
    logic       tick, von, ls, fs, hs, vs;
    logic [3:0] col;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_a  = 0;

  logic        rst_a, rst_b, rst_c;
  logic [3:0]  rgb_a;
  logic [3:0]  rb_r, rb_g, rb_b;
  logic [10:0] h_a, h_b, h_c;
  logic [9:0]  v_a, v_b, v_c;
  logic        tick_a, von_a, ls_a, fs_a, hs_a, vs_a;
  logic        tick_b, von_b, ls_b, fs_b, hs_b, vs_b;
  logic        tick_c, von_c, ls_c, fs_c, hs_c, vs_c;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic [1:0]  hst_b, vst_b;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a), .rgb_in_r(rgb_a), .rgb_in_g(rgb_a), .rgb_in_b(rgb_a),
    .h_cnt(h_a), .v_cnt(v_a), .pix_tick(tick_a), .video_on(von_a), .line_start(ls_a),
    .frame_start(fs_a), .vga_hs(hs_a), .vga_vs(vs_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .rgb_in_r(rb_r), .rgb_in_g(rb_g), .rgb_in_b(rb_b),
    .h_cnt(h_b), .v_cnt(v_b), .pix_tick(tick_b), .video_on(von_b), .line_start(ls_b),
    .frame_start(fs_b), .vga_hs(hs_b), .vga_vs(vs_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_c (
    .clk(clk), .rst_n(rst_c), .rgb_in_r(4'h0), .rgb_in_g(4'h0), .rgb_in_b(4'h0),
    .h_cnt(h_c), .v_cnt(v_c), .pix_tick(tick_c), .video_on(von_c), .line_start(ls_c),
    .frame_start(fs_c), .vga_hs(hs_c), .vga_vs(vs_c), .vga_r(r_c), .vga_g(g_c), .vga_b(b_c)
  );

  assign hst_b = dut_b.h_state;
  assign vst_b = dut_b.v_state;

  vec_t vecs[12];

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Phase of a scan position: 0 active, 1 front porch, 2 sync, 3 back porch.
  function automatic logic [1:0] phaseOf(input int pos, input int a, input int f, input int s);
    if (pos < a) return 2'd0;
    if (pos < a + f) return 2'd1;
    if (pos < a + f + s) return 2'd2;
    return 2'd3;
  endfunction

  task automatic applyStimulus(input int idx, input vec_t vv);
    rgb_a = vv.rgb;
    while (cyc_a < vv.cyc) begin
      stepClk();
      cyc_a++;
    end
    checkOutput($sformatf("A[%0d] h_cnt", idx), 64'(h_a), 64'(vv.h));
    checkOutput($sformatf("A[%0d] v_cnt", idx), 64'(v_a), 64'(vv.v));
    checkOutput($sformatf("A[%0d] flags", idx),
                64'({tick_a, von_a, ls_a, fs_a, hs_a, vs_a}),
                64'({vv.tick, vv.von, vv.ls, vv.fs, vv.hs, vv.vs}));
    checkOutput($sformatf("A[%0d] rgb", idx), 64'({r_a, g_a, b_a}), 64'({vv.col, vv.col, vv.col}));
  endtask

  // Shrunken build: 15 pixels x 8 lines, CLK_DIV=2; every cycle compared against a closed-form scan model.
  task automatic runB(input int cycles);
    int p, h, v, hq, vq, lineTicks, lines;
    logic seenLs, seenFs, exHs, exVs;
    logic [3:0] c;
    logic [11:0] exCol;
    lineTicks = 0; lines = 0; seenLs = 1'b0; seenFs = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      p = n / 2;
      h = p % 15;
      v = (p / 15) % 8;
      rb_r = 4'(h + v);
      rb_g = ~rb_r;
      rb_b = rb_r ^ 4'h5;
      if (p == 0) begin
        exHs = 1'b1; exVs = 1'b1; exCol = 12'h000;
      end else begin
        hq = (p - 1) % 15;
        vq = ((p - 1) / 15) % 8;
        c = 4'(hq + vq);
        exHs = !(hq >= 10 && hq <= 12);
        exVs = !(vq >= 5 && vq <= 6);
        exCol = (hq < 8 && vq < 4) ? {c, ~c, c ^ 4'h5} : 12'h000;
      end
      checkOutput($sformatf("B n=%0d scan", n),
        64'({h_b, v_b, tick_b, von_b, ls_b, fs_b, hs_b, vs_b, r_b, g_b, b_b, hst_b, vst_b}),
        64'({11'(h), 10'(v), (n % 2 == 1), (h < 8 && v < 4), (n % 2 == 1 && h == 0),
             (n % 2 == 1 && h == 0 && v == 0), exHs, exVs, exCol,
             phaseOf(h, 8, 2, 3), phaseOf(v, 4, 1, 2)}));
      if (tick_b) lineTicks++;
      if (ls_b) begin
        if (seenLs) checkOutput("B line period ticks", 64'(lineTicks), 64'd15);
        seenLs = 1'b1;
        lineTicks = 0;
        if (fs_b) begin
          if (seenFs) checkOutput("B lines per frame", 64'(lines), 64'd8);
          seenFs = 1'b1;
          lines = 0;
        end
        lines++;
      end
      stepClk();
    end
  endtask

  initial begin
    int tickCnt, hsLow, lastLs;
    logic done;

    vecs[0]  = '{0,    4'hF, 0,   0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[1]  = '{3,    4'hA, 0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0};
    vecs[2]  = '{4,    4'hA, 1,   0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hA};
    vecs[3]  = '{2560, 4'hF, 640, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hF};
    vecs[4]  = '{2564, 4'hF, 641, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[5]  = '{2624, 4'hF, 656, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[6]  = '{2628, 4'hF, 657, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[7]  = '{3008, 4'hF, 752, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0};
    vecs[8]  = '{3012, 4'hF, 753, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[9]  = '{3199, 4'hF, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[10] = '{3203, 4'hF, 0,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0};
    vecs[11] = '{3204, 4'h5, 1,   1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    rgb_a = 4'hF; rb_r = 4'hF; rb_g = 4'hF; rb_b = 4'hF;
    repeat (3) stepClk();

    $display("[TB] default build: reset and line timing");
    checkOutput("A reset state",
      64'({h_a, v_a, tick_a, von_a, ls_a, fs_a, hs_a, vs_a, r_a, g_a, b_a}),
      64'({11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}));
    rst_a = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);

    tickCnt = 0; hsLow = 0; done = 1'b0;
    for (int k = 0; k < 4000 && !done; k++) begin
      stepClk();
      if (tick_a) begin
        tickCnt++;
        if (!hs_a) hsLow++;
      end
      if (ls_a) done = 1'b1;
    end
    checkOutput("A line_start seen", 64'(done), 64'd1);
    checkOutput("A ticks per line", 64'(tickCnt), 64'd800);
    checkOutput("A hsync low ticks", 64'(hsLow), 64'd96);

    $display("[TB] small build: frames and mid-frame reset");
    rst_b = 1'b1;
    runB(322);
    checkOutput("B pre-reset position", 64'({h_b, v_b, hs_b}), 64'({11'd11, 10'd2, 1'b0}));
    rst_b = 1'b0;
    stepClk();
    checkOutput("B mid-frame reset",
      64'({h_b, v_b, tick_b, von_b, ls_b, fs_b, hs_b, vs_b, r_b, g_b, b_b, hst_b, vst_b}),
      64'({11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 2'd0, 2'd0}));
    rst_b = 1'b1;
    runB(300);

    $display("[TB] CLK_DIV=1 build");
    checkOutput("C reset state",
      64'({h_c, v_c, tick_c, von_c, ls_c, fs_c, hs_c, vs_c, r_c, g_c, b_c}),
      64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000}));
    rst_c = 1'b1;
    lastLs = -1;
    for (int n = 0; n < 1700; n++) begin
      checkOutput($sformatf("C n=%0d scan", n), 64'({tick_c, h_c, ls_c}),
                  64'({1'b1, 11'(n % 800), (n % 800 == 0)}));
      if (ls_c) begin
        if (lastLs >= 0) checkOutput("C line period clk", 64'(n - lastLs), 64'd800);
        lastLs = n;
      end
      stepClk();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
